// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 key-search control slice.
//   state_t            : top-level scheduler states
//   SEL_*              : owner encodings for the shared s RAM port mux
//   CHAR_*             : plaintext character bounds used by the byte checker
//   DEFAULT_MESSAGE_LENGTH : default message size in bytes
package rc4_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT_GO,
    ST_INIT_WAIT,
    ST_KSA_GO,
    ST_KSA_WAIT,
    ST_DEC_GO,
    ST_DEC_WAIT,
    ST_CHK_ADDR,
    ST_CHK_DATA,
    ST_NEXT_KEY,
    ST_DONE
  } state_t;

  localparam logic [1:0] SEL_INIT = 2'b00;
  localparam logic [1:0] SEL_KSA  = 2'b01;
  localparam logic [1:0] SEL_DEC  = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  localparam logic [7:0] CHAR_A     = 8'h61;
  localparam logic [7:0] CHAR_Z     = 8'h7A;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  localparam int DEFAULT_MESSAGE_LENGTH = 32;

endpackage

// File: rtl/plaintext_byte_check.sv
// Combinational plaintext test for one decrypted byte.
// A byte is acceptable if it is a lowercase letter 'a'..'z' or a space.
//   data  : byte under test
//   valid : 1 when data is acceptable plaintext
module plaintext_byte_check
  import rc4_pkg::*;
(
  input  logic [7:0] data,
  output logic       valid
);

  assign valid = ((data >= CHAR_A) && (data <= CHAR_Z)) || (data == CHAR_SPACE);

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// Top-level scheduler for the RC4 cracking datapath. For every candidate key
// it runs the S-box init, KSA and decrypt phase FSMs in turn, then scans the
// decrypted RAM for plaintext and either reports the key or moves to the next.
//   clock, reset_n            : rising-edge clock, async active-low reset
//   start                     : begin a search (sampled only in IDLE)
//   init/ksa/dec_start        : one-cycle start pulses to the phase FSMs
//   init/ksa/dec_finish       : one-cycle done pulses from the phase FSMs
//   s_sel                     : s RAM owner select (00 init, 01 KSA, 10 dec, 11 none)
//   key                       : current candidate key
//   dram_addr, dram_q         : decrypted RAM read port (1-cycle read latency)
//   busy, found, fail, timeout: search status
module rc4_key_search_ctrl
  import rc4_pkg::*;
#(
  parameter int                   MESSAGE_LENGTH  = DEFAULT_MESSAGE_LENGTH,
  parameter int                   KEY_WIDTH       = 24,
  parameter logic [KEY_WIDTH-1:0] KEY_FIRST       = '0,
  parameter logic [KEY_WIDTH-1:0] KEY_LAST        = KEY_WIDTH'(24'h3FFFFF),
  parameter int                   WATCHDOG_CYCLES = 8192
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  output logic                 init_start,
  input  logic                 init_finish,
  output logic                 ksa_start,
  input  logic                 ksa_finish,
  output logic                 dec_start,
  input  logic                 dec_finish,
  output logic [1:0]           s_sel,
  output logic [KEY_WIDTH-1:0] key,
  output logic [7:0]           dram_addr,
  input  logic [7:0]           dram_q,
  output logic                 busy,
  output logic                 found,
  output logic                 fail,
  output logic                 timeout
);

  // The counter only has to hold 0..WATCHDOG_CYCLES-1.
  localparam int              WD_W    = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);
  localparam logic [7:0]      IDX_LAST = 8'(MESSAGE_LENGTH - 1);

  state_t               state, state_nxt;
  logic [KEY_WIDTH-1:0] key_nxt;
  logic [7:0]           idx, idx_nxt;
  logic [WD_W-1:0]      wd_cnt, wd_nxt;
  logic                 found_nxt, fail_nxt, timeout_nxt;
  logic                 byte_ok;

  // Shared phase-wait handling, selected by the WAIT state being served.
  logic                 wait_active, wait_fin;
  state_t               wait_next;
  logic                 wd_expired;

  plaintext_byte_check u_byte_check (
    .data  (dram_q),
    .valid (byte_ok)
  );

  assign dram_addr  = idx;
  assign wd_expired = (WATCHDOG_CYCLES != 0) && (wd_cnt == WD_LAST);

  always_comb begin
    state_nxt   = state;
    key_nxt     = key;
    idx_nxt     = idx;
    wd_nxt      = wd_cnt;
    found_nxt   = found;
    fail_nxt    = fail;
    timeout_nxt = timeout;
    init_start  = 1'b0;
    ksa_start   = 1'b0;
    dec_start   = 1'b0;
    s_sel       = SEL_NONE;
    busy        = 1'b1;
    wait_active = 1'b0;
    wait_fin    = 1'b0;
    wait_next   = ST_DONE;

    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt   = ST_INIT_GO;
          key_nxt     = KEY_FIRST;
          found_nxt   = 1'b0;
          fail_nxt    = 1'b0;
          timeout_nxt = 1'b0;
        end
      end
      ST_INIT_GO: begin
        init_start = 1'b1;
        s_sel      = SEL_INIT;
        wd_nxt     = '0;
        state_nxt  = ST_INIT_WAIT;
      end
      ST_INIT_WAIT: begin
        s_sel       = SEL_INIT;
        wait_active = 1'b1;
        wait_fin    = init_finish;
        wait_next   = ST_KSA_GO;
      end
      ST_KSA_GO: begin
        ksa_start = 1'b1;
        s_sel     = SEL_KSA;
        wd_nxt    = '0;
        state_nxt = ST_KSA_WAIT;
      end
      ST_KSA_WAIT: begin
        s_sel       = SEL_KSA;
        wait_active = 1'b1;
        wait_fin    = ksa_finish;
        wait_next   = ST_DEC_GO;
      end
      ST_DEC_GO: begin
        dec_start = 1'b1;
        s_sel     = SEL_DEC;
        wd_nxt    = '0;
        state_nxt = ST_DEC_WAIT;
      end
      ST_DEC_WAIT: begin
        s_sel       = SEL_DEC;
        idx_nxt     = '0;
        wait_active = 1'b1;
        wait_fin    = dec_finish;
        wait_next   = ST_CHK_ADDR;
      end
      ST_CHK_ADDR: begin
        state_nxt = ST_CHK_DATA;
      end
      ST_CHK_DATA: begin
        // Early exit on the first non-plaintext byte.
        if (!byte_ok) begin
          state_nxt = ST_NEXT_KEY;
        end else if (idx == IDX_LAST) begin
          found_nxt = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          idx_nxt   = idx + 8'd1;
          state_nxt = ST_CHK_ADDR;
        end
      end
      ST_NEXT_KEY: begin
        if (key == KEY_LAST) begin
          fail_nxt  = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          key_nxt   = key + KEY_WIDTH'(1);
          state_nxt = ST_INIT_GO;
        end
      end
      ST_DONE: begin
        busy      = 1'b0;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Finish pulses from phases other than the one being waited on never
    // reach here, so stray pulses are ignored by construction.
    if (wait_active) begin
      if (wait_fin) begin
        state_nxt = wait_next;
      end else if (wd_expired) begin
        fail_nxt    = 1'b1;
        timeout_nxt = 1'b1;
        state_nxt   = ST_DONE;
      end else begin
        wd_nxt = wd_cnt + WD_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      key     <= KEY_FIRST;
      idx     <= '0;
      wd_cnt  <= '0;
      found   <= 1'b0;
      fail    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      key     <= key_nxt;
      idx     <= idx_nxt;
      wd_cnt  <= wd_nxt;
      found   <= found_nxt;
      fail    <= fail_nxt;
      timeout <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
module tb_rc4_key_search_ctrl;

  localparam int          ML  = 4;
  localparam int          KF  = 0;
  localparam int          KL  = 7;
  localparam int          WDC = 50;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        init_start, ksa_start, dec_start;
  logic        init_finish, ksa_finish, dec_finish;
  logic [1:0]  s_sel;
  logic [23:0] key;
  logic [7:0]  dram_addr;
  logic [7:0]  dram_q;
  logic        busy, found, fail, timeout;

  int total = 0;
  int bad   = 0;

  // Environment configuration shared by the models.
  int          lat_g   = 3;
  int          good_g  = -1;
  int          bpos_g  = 0;
  logic [7:0]  bbyte_g = 8'h41;
  bit          ksa_hang = 1'b0;
  logic        inj_init = 1'b0;

  logic [7:0] init_cnt, ksa_cnt, dec_cnt;
  logic [7:0] inv_bytes [6] = '{8'h60, 8'h7B, 8'h1F, 8'h21, 8'h41, 8'h00};
  logic [7:0] good_text [4] = '{8'h61, 8'h62, 8'h63, 8'h20};

  always #5 clock = ~clock;

  rc4_key_search_ctrl #(
    .MESSAGE_LENGTH (ML),
    .KEY_WIDTH      (24),
    .KEY_FIRST      (24'(KF)),
    .KEY_LAST       (24'(KL)),
    .WATCHDOG_CYCLES(WDC)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .init_start (init_start),
    .init_finish(init_finish),
    .ksa_start  (ksa_start),
    .ksa_finish (ksa_finish),
    .dec_start  (dec_start),
    .dec_finish (dec_finish),
    .s_sel      (s_sel),
    .key        (key),
    .dram_addr  (dram_addr),
    .dram_q     (dram_q),
    .busy       (busy),
    .found      (found),
    .fail       (fail),
    .timeout    (timeout)
  );

  // Phase models: finish pulse lat_g cycles after the start pulse is taken.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      init_cnt <= 8'd0;
      ksa_cnt  <= 8'd0;
      dec_cnt  <= 8'd0;
    end else begin
      if (init_start) init_cnt <= 8'(lat_g);
      else if (init_cnt != 0) init_cnt <= init_cnt - 8'd1;
      if (ksa_start && !ksa_hang) ksa_cnt <= 8'(lat_g);
      else if (ksa_cnt != 0) ksa_cnt <= ksa_cnt - 8'd1;
      if (dec_start) dec_cnt <= 8'(lat_g);
      else if (dec_cnt != 0) dec_cnt <= dec_cnt - 8'd1;
    end
  end

  assign init_finish = (init_cnt == 8'd1) || inj_init;
  assign ksa_finish  = (ksa_cnt == 8'd1);
  assign dec_finish  = (dec_cnt == 8'd1);

  // Decrypted RAM: the good key yields "abc " repeated; any other key yields
  // valid letters before bpos_g and an invalid byte at bpos_g.
  function automatic logic [7:0] mem_byte(input logic [23:0] k, input logic [7:0] a);
    int v;
    if (int'(k) == good_g) return good_text[int'(a) % 4];
    if (int'(a) < bpos_g) begin
      v = (int'(k) * 7 + int'(a) * 13) % 27;
      return (v < 26) ? 8'(8'h61 + v) : 8'h20;
    end
    return bbyte_g;
  endfunction

  always @(posedge clock) dram_q <= mem_byte(key, dram_addr);

  typedef struct {
    bit found, fail, tmo, done_seen;
    int key, busy_cyc, n_init, n_ksa, n_dec, sel_err, ksa_cyc, fail_cyc;
  } res_t;

  typedef struct {
    int lat; int good; int bpos; logic [7:0] bbyte;
    bit exp_found; bit exp_fail; int exp_key; int exp_busy; int exp_passes;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Search outcome from the key-range rules and per-phase cycle costs:
  // each pass = 3 phases of (1 go + lat wait), 2 cycles per byte read,
  // plus 1 cycle to step the key when the pass is rejected.
  function automatic void ref_model(input int lat, input int good, input int bpos,
                                    output bit f, output int k, output int cyc,
                                    output int passes);
    f = 1'b0; k = KL; cyc = 0; passes = 0;
    for (int kk = KF; kk <= KL; kk++) begin
      passes++;
      cyc += 3 * (1 + lat);
      if (kk == good) begin
        cyc += 2 * ML;
        f = 1'b1;
        k = kk;
        return;
      end
      cyc += 2 * (bpos + 1) + 1;
    end
  endfunction

  task automatic run(input int lat, input int good, input int bpos, input logic [7:0] bbyte,
                     input bit hold, input bit inject, output res_t r);
    logic [1:0] prev_sel;
    int inj_at;
    r = '{default: 0};
    r.ksa_cyc = -1;
    r.fail_cyc = -1;
    inj_at = -1;
    lat_g = lat; good_g = good; bpos_g = bpos; bbyte_g = bbyte;
    @(negedge clock);
    start = 1'b1;
    prev_sel = s_sel;
    @(negedge clock);
    if (!hold) start = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (inj_at >= 0 && c == inj_at) inj_init = 1'b1;
      else inj_init = 1'b0;
      if (init_start) begin r.n_init++; if (s_sel != 2'b00) r.sel_err++; end
      if (ksa_start) begin
        r.n_ksa++;
        if (s_sel != 2'b01) r.sel_err++;
        if (r.ksa_cyc < 0) begin
          r.ksa_cyc = c;
          if (inject) inj_at = c + 1;
        end
      end
      if (dec_start) begin r.n_dec++; if (s_sel != 2'b10) r.sel_err++; end
      if (s_sel != prev_sel && !init_start && !ksa_start && !dec_start && s_sel != 2'b11)
        r.sel_err++;
      prev_sel = s_sel;
      if (fail && r.fail_cyc < 0) r.fail_cyc = c;
      if (!busy) begin
        r.done_seen = 1'b1;
        r.found = found; r.fail = fail; r.tmo = timeout; r.key = int'(key);
        if (s_sel != 2'b11) r.sel_err++;
        break;
      end
      r.busy_cyc++;
      @(negedge clock);
    end
    inj_init = 1'b0;
    start = 1'b0;
    @(negedge clock);
  endtask

  vec_t vecs [4];
  res_t r;

  initial begin
    bit   ef;
    int   ek, ecyc, epass, n, g;
    logic [7:0] bb;

    vecs[0] = '{3,  0, 0, 8'h41, 1'b1, 1'b0, 0,  20, 1};
    vecs[1] = '{3,  5, 0, 8'h7B, 1'b1, 1'b0, 5,  95, 6};
    vecs[2] = '{1, -1, 3, 8'h60, 1'b0, 1'b1, 7, 120, 8};
    vecs[3] = '{2,  7, 1, 8'h1F, 1'b1, 1'b0, 7, 115, 8};

    reset_n = 1'b0;
    start   = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_s_sel", int'(s_sel), 3);
    chk("rst_init_start", int'(init_start), 0);
    chk("rst_ksa_start", int'(ksa_start), 0);
    chk("rst_dec_start", int'(dec_start), 0);
    chk("rst_dram_addr", int'(dram_addr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_found", int'(found), 0);
    chk("rst_fail", int'(fail), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_key", int'(key), KF);

    foreach (vecs[i]) begin
      run(vecs[i].lat, vecs[i].good, vecs[i].bpos, vecs[i].bbyte, 1'b0, 1'b0, r);
      chk($sformatf("v%0d_done", i), int'(r.done_seen), 1);
      chk($sformatf("v%0d_found", i), int'(r.found), int'(vecs[i].exp_found));
      chk($sformatf("v%0d_fail", i), int'(r.fail), int'(vecs[i].exp_fail));
      chk($sformatf("v%0d_timeout", i), int'(r.tmo), 0);
      chk($sformatf("v%0d_key", i), r.key, vecs[i].exp_key);
      chk($sformatf("v%0d_busy_cycles", i), r.busy_cyc, vecs[i].exp_busy);
      chk($sformatf("v%0d_init_pulses", i), r.n_init, vecs[i].exp_passes);
      chk($sformatf("v%0d_ksa_pulses", i), r.n_ksa, vecs[i].exp_passes);
      chk($sformatf("v%0d_dec_pulses", i), r.n_dec, vecs[i].exp_passes);
      chk($sformatf("v%0d_s_sel", i), r.sel_err, 0);
    end

    // KSA never finishes: watchdog fires after WDC wait cycles.
    ksa_hang = 1'b1;
    run(3, 0, 0, 8'h41, 1'b0, 1'b0, r);
    ksa_hang = 1'b0;
    chk("wd_done", int'(r.done_seen), 1);
    chk("wd_fail", int'(r.fail), 1);
    chk("wd_timeout", int'(r.tmo), 1);
    chk("wd_found", int'(r.found), 0);
    chk("wd_latency", r.fail_cyc - r.ksa_cyc, WDC + 1);
    chk("wd_busy_cycles", r.busy_cyc, 1 + 3 + 1 + WDC);
    chk("wd_dec_pulses", r.n_dec, 0);
    chk("wd_s_sel", r.sel_err, 0);

    // start held high, stray init_finish while KSA owns the RAM.
    run(4, 0, 0, 8'h41, 1'b1, 1'b1, r);
    chk("hold_found", int'(r.found), 1);
    chk("hold_timeout", int'(r.tmo), 0);
    chk("hold_init_pulses", r.n_init, 1);
    chk("hold_ksa_pulses", r.n_ksa, 1);
    chk("hold_busy_cycles", r.busy_cyc, 3 * 5 + 2 * ML);
    chk("hold_s_sel", r.sel_err, 0);

    // Asynchronous reset in DEC_WAIT of the second candidate.
    lat_g = 5; good_g = -1; bpos_g = 3; bbyte_g = 8'h41;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    for (int c = 0; c < 2000; c++) begin
      if (dec_start) n++;
      if (n == 2) break;
      @(negedge clock);
    end
    chk("arst_reach_dec", n, 2);
    @(negedge clock);
    @(negedge clock);
    chk("arst_key_before", int'(key), KF + 1);
    chk("arst_sel_before", int'(s_sel), 2);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_s_sel", int'(s_sel), 3);
    chk("arst_busy", int'(busy), 0);
    chk("arst_key", int'(key), KF);
    chk("arst_starts", int'({init_start, ksa_start, dec_start}), 0);
    chk("arst_flags", int'({found, fail, timeout}), 0);
    chk("arst_dram_addr", int'(dram_addr), 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    run(3, 2, 0, 8'h41, 1'b0, 1'b0, r);
    chk("arst_rerun_found", int'(r.found), 1);
    chk("arst_rerun_key", r.key, 2);
    chk("arst_rerun_busy", r.busy_cyc, 50);
    chk("arst_rerun_init_pulses", r.n_init, 3);

    // Randomized searches against the reference model.
    for (int it = 0; it < 10; it++) begin
      g  = int'($urandom_range(0, 10));
      bb = inv_bytes[$urandom_range(0, 5)];
      lat_g = int'($urandom_range(1, 5));
      good_g = (g > KL) ? -1 : g;
      bpos_g = int'($urandom_range(0, ML - 1));
      ref_model(lat_g, good_g, bpos_g, ef, ek, ecyc, epass);
      run(lat_g, good_g, bpos_g, bb, 1'b0, 1'b0, r);
      chk($sformatf("rnd%0d_found", it), int'(r.found), int'(ef));
      chk($sformatf("rnd%0d_fail", it), int'(r.fail), int'(!ef));
      chk($sformatf("rnd%0d_timeout", it), int'(r.tmo), 0);
      chk($sformatf("rnd%0d_key", it), r.key, ek);
      chk($sformatf("rnd%0d_busy_cycles", it), r.busy_cyc, ecyc);
      chk($sformatf("rnd%0d_init_pulses", it), r.n_init, epass);
      chk($sformatf("rnd%0d_s_sel", it), r.sel_err, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
